// File: rtl/sd_card_pkg.sv
// Shared types, constants and the serial CRC7 step used by the SD card-side
// command responder.
package sd_card_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_WAIT = 2'd2,
        ST_TX   = 2'd3
    } state_t;

    localparam int         CMD_TOKEN_LEN = 48;
    localparam int         RSP_LONG_LEN  = 136;
    localparam logic [6:0] CRC7_POLY     = 7'h09;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_card_crc7.sv
// Serial CRC7 (x^7+x^3+1); clear with enable loads the first bit in the same cycle.
module sd_card_crc7
    import sd_card_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    // CRC remainder register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 7'h00;
        end else if (clr) begin
            crc <= en ? crc7_step(7'h00, din) : 7'h00;
        end else if (en) begin
            crc <= crc7_step(crc, din);
        end
    end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line responder: receives 48-bit command tokens, then sends
// a 48-bit or 136-bit response after at least NCR_MIN idle cycles.
module sd_card_cmd_responder
    import sd_card_pkg::*;
#(
    parameter int NCR_MIN = 2
) (
    input  logic         sd_clk,
    input  logic         rst,
    input  logic         sd_cmd_to_card,
    output logic         sd_cmd_from_card,
    output logic         sd_cmd_oe,
    output logic         cmd_valid,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_arg,
    output logic         cmd_crc_ok,
    output logic         cmd_frame_err,
    input  logic         rsp_valid,
    output logic         rsp_ready,
    input  logic         rsp_skip,
    input  logic         rsp_long,
    input  logic         rsp_nocrc,
    input  logic [5:0]   rsp_index,
    input  logic [127:0] rsp_data
);

    localparam logic [6:0] NCR_GO    = 7'(NCR_MIN - 1);
    localparam logic [7:0] SHORT_LEN = 8'(CMD_TOKEN_LEN);
    localparam logic [7:0] LONG_LEN  = 8'(RSP_LONG_LEN);

    state_t         state_r, state_next;
    logic [7:0]     bit_cnt_r;
    logic [6:0]     ncr_r;
    logic [45:0]    rx_sr_r;
    logic [135:0]   tx_sr_r;
    logic           have_rsp_r, tx_long_r, tx_crc_ins_r;
    logic [6:0]     rx_crc, tx_crc;

    logic           hs_s, skip_s, go_tx_s, rx_start_s, rx_done_s, tx_end_s;
    logic           long_s, ins_s;
    logic [46:0]    token_s;
    logic [135:0]   built_s, frame_s, tx_bits_s;
    logic [7:0]     tx_len_s;

    // Response frame assembly, left-aligned in a 136-bit field, and CRC splice
    always_comb begin
        built_s = 136'h0;
        if (rsp_long) begin
            built_s = {2'b00, 6'b111111, rsp_data[127:1], 1'b1};
        end else begin
            built_s = {2'b00, rsp_index, rsp_data[31:0], (rsp_nocrc ? 7'h7F : 7'h00), 1'b1, 88'h0};
        end
        frame_s  = have_rsp_r ? tx_sr_r : built_s;
        long_s   = have_rsp_r ? tx_long_r : rsp_long;
        ins_s    = have_rsp_r ? tx_crc_ins_r : (!rsp_long && !rsp_nocrc);
        tx_bits_s = tx_sr_r;
        if (tx_crc_ins_r && (bit_cnt_r == 8'd40)) begin
            tx_bits_s[135:129] = tx_crc;
        end else begin
            tx_bits_s = tx_sr_r;
        end
        tx_len_s = tx_long_r ? LONG_LEN : SHORT_LEN;
        token_s  = {rx_sr_r, sd_cmd_to_card};
    end

    // Next-state logic and per-cycle event strobes
    always_comb begin
        hs_s       = (state_r == ST_WAIT) && rsp_valid && rsp_ready;
        skip_s     = hs_s && rsp_skip;
        go_tx_s    = (state_r == ST_WAIT) && (have_rsp_r || (hs_s && !rsp_skip)) && (ncr_r >= NCR_GO);
        rx_start_s = !sd_cmd_to_card &&
                     ((state_r == ST_IDLE) || ((state_r == ST_WAIT) && !have_rsp_r && !hs_s));
        rx_done_s  = (state_r == ST_RX) && (bit_cnt_r == 8'd47);
        tx_end_s   = (state_r == ST_TX) && (bit_cnt_r == tx_len_s);
        state_next = state_r;
        case (state_r)
            ST_IDLE: state_next = rx_start_s ? ST_RX : ST_IDLE;
            ST_RX:   state_next = rx_done_s ? ST_WAIT : ST_RX;
            ST_WAIT: begin
                if (go_tx_s) begin
                    state_next = ST_TX;
                end else if (skip_s) begin
                    state_next = ST_IDLE;
                end else if (rx_start_s) begin
                    state_next = ST_RX;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_TX:   state_next = tx_end_s ? ST_IDLE : ST_TX;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Receive shifter, handshake capture, Ncr timing and transmit shifter
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r        <= 8'd0;
            ncr_r            <= 7'd0;
            rx_sr_r          <= 46'h0;
            tx_sr_r          <= 136'h0;
            have_rsp_r       <= 1'b0;
            tx_long_r        <= 1'b0;
            tx_crc_ins_r     <= 1'b0;
            sd_cmd_from_card <= 1'b1;
            sd_cmd_oe        <= 1'b0;
            cmd_valid        <= 1'b0;
            cmd_index        <= 6'd0;
            cmd_arg          <= 32'd0;
            cmd_crc_ok       <= 1'b0;
            cmd_frame_err    <= 1'b0;
            rsp_ready        <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rx_start_s) begin
                        bit_cnt_r <= 8'd1;
                    end
                end
                ST_RX: begin
                    rx_sr_r   <= {rx_sr_r[44:0], sd_cmd_to_card};
                    bit_cnt_r <= bit_cnt_r + 8'd1;
                    if (rx_done_s) begin
                        cmd_valid     <= 1'b1;
                        cmd_index     <= token_s[45:40];
                        cmd_arg       <= token_s[39:8];
                        cmd_crc_ok    <= (token_s[7:1] == rx_crc);
                        cmd_frame_err <= !token_s[46] || !token_s[0];
                        ncr_r         <= 7'd0;
                        rsp_ready     <= 1'b1;
                        have_rsp_r    <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (ncr_r != 7'h7F) begin
                        ncr_r <= ncr_r + 7'd1;
                    end
                    if (hs_s) begin
                        rsp_ready <= 1'b0;
                        if (!rsp_skip) begin
                            have_rsp_r   <= 1'b1;
                            tx_sr_r      <= built_s;
                            tx_long_r    <= rsp_long;
                            tx_crc_ins_r <= !rsp_long && !rsp_nocrc;
                        end
                    end
                    // A new start bit before any response was captured abandons the old command
                    if (rx_start_s) begin
                        rsp_ready <= 1'b0;
                        bit_cnt_r <= 8'd1;
                    end
                    if (go_tx_s) begin
                        sd_cmd_oe        <= 1'b1;
                        sd_cmd_from_card <= frame_s[135];
                        tx_sr_r          <= {frame_s[134:0], 1'b0};
                        tx_long_r        <= long_s;
                        tx_crc_ins_r     <= ins_s;
                        have_rsp_r       <= 1'b0;
                        bit_cnt_r        <= 8'd1;
                        rsp_ready        <= 1'b0;
                    end
                end
                ST_TX: begin
                    if (tx_end_s) begin
                        sd_cmd_oe        <= 1'b0;
                        sd_cmd_from_card <= 1'b1;
                    end else begin
                        sd_cmd_from_card <= tx_bits_s[135];
                        tx_sr_r          <= {tx_bits_s[134:0], 1'b0};
                        bit_cnt_r        <= bit_cnt_r + 8'd1;
                    end
                end
                default: bit_cnt_r <= 8'd0;
            endcase
        end
    end

    sd_card_crc7 u_rx_crc (
        .clk (sd_clk),
        .rst (rst),
        .clr (rx_start_s),
        .en  (rx_start_s || ((state_r == ST_RX) && (bit_cnt_r < 8'd40))),
        .din (sd_cmd_to_card),
        .crc (rx_crc)
    );

    sd_card_crc7 u_tx_crc (
        .clk (sd_clk),
        .rst (rst),
        .clr (go_tx_s),
        .en  (go_tx_s || ((state_r == ST_TX) && (bit_cnt_r < 8'd40))),
        .din (go_tx_s ? frame_s[135] : tx_sr_r[135]),
        .crc (tx_crc)
    );

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Scoreboard bench for sd_card_cmd_responder: directed command tokens and
// responses, with decoupled monitors for decoded commands and CMD-line frames.
module tb_sd_card_cmd_responder;

    localparam int NCR_MIN = 2;

    logic         sd_clk = 1'b0;
    logic         rst = 1'b1;
    logic         sd_cmd_to_card = 1'b1;
    logic         sd_cmd_from_card, sd_cmd_oe, cmd_valid, cmd_crc_ok, cmd_frame_err, rsp_ready;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic         rsp_valid = 1'b0, rsp_skip = 1'b0, rsp_long = 1'b0, rsp_nocrc = 1'b0;
    logic [5:0]   rsp_index = 6'd0;
    logic [127:0] rsp_data = 128'h0;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic        ok;
        logic        ferr;
        int          at;
    } cmd_exp_t;

    typedef struct {
        logic [135:0] bits;
        int           len;
        int           start;
        int           abort_at;
    } rsp_exp_t;

    cmd_exp_t exp_cmd[$];
    rsp_exp_t exp_rsp[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_e0 = 0;
    int last_start = 0;
    int abort_next = 0;
    int oe_rises = 0;
    bit mon_active = 1'b0;

    sd_card_cmd_responder #(.NCR_MIN(NCR_MIN)) dut (
        .sd_clk           (sd_clk),
        .rst              (rst),
        .sd_cmd_to_card   (sd_cmd_to_card),
        .sd_cmd_from_card (sd_cmd_from_card),
        .sd_cmd_oe        (sd_cmd_oe),
        .cmd_valid        (cmd_valid),
        .cmd_index        (cmd_index),
        .cmd_arg          (cmd_arg),
        .cmd_crc_ok       (cmd_crc_ok),
        .cmd_frame_err    (cmd_frame_err),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_skip         (rsp_skip),
        .rsp_long         (rsp_long),
        .rsp_nocrc        (rsp_nocrc),
        .rsp_index        (rsp_index),
        .rsp_data         (rsp_data)
    );

    always #5 sd_clk = ~sd_clk;

    always @(posedge sd_clk) cyc <= cyc + 1;

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] crc7_model(input logic [39:0] msg);
        logic [46:0] rem;
        rem = {msg, 7'h00};
        for (int i = 46; i >= 7; i--) begin
            if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
        end
        return rem[6:0];
    endfunction

    function automatic logic [47:0] mk_token(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, crc7_model({2'b01, idx, arg}), 1'b1};
    endfunction

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sd_clk);
            #1;
        end
    endtask

    task automatic send_token(input logic [47:0] tok, input logic [5:0] idx, input logic [31:0] arg,
                              input logic ok, input logic ferr);
        cmd_exp_t e;
        last_e0 = cyc + 1;
        e.idx = idx; e.arg = arg; e.ok = ok; e.ferr = ferr; e.at = last_e0 + 47;
        exp_cmd.push_back(e);
        for (int k = 0; k < 48; k++) begin
            sd_cmd_to_card = tok[47-k];
            tick(1);
        end
        sd_cmd_to_card = 1'b1;
    endtask

    task automatic respond(input logic skip, input logic lng, input logic nocrc, input logic [5:0] idx,
                           input logic [127:0] data, input logic [135:0] exp_bits);
        rsp_exp_t r;
        int h;
        check("rsp_ready_before_hs", rsp_ready, 1);
        rsp_valid = 1'b1; rsp_skip = skip; rsp_long = lng; rsp_nocrc = nocrc;
        rsp_index = idx; rsp_data = data;
        h = cyc;
        if (!skip) begin
            r.bits = exp_bits;
            r.len = lng ? 136 : 48;
            r.start = (last_e0 + 47 + NCR_MIN > h + 1) ? last_e0 + 47 + NCR_MIN : h + 1;
            r.abort_at = abort_next;
            last_start = r.start;
            exp_rsp.push_back(r);
        end
        tick(1);
        rsp_valid = 1'b0; rsp_skip = 1'b0; rsp_long = 1'b0; rsp_nocrc = 1'b0;
        rsp_index = 6'd0; rsp_data = 128'h0;
        check("rsp_ready_after_hs", rsp_ready, 0);
    endtask

    task automatic wait_rsp_done();
        int i;
        i = 0;
        while ((exp_rsp.size() != 0 || mon_active) && i < 400) begin
            tick(1);
            i++;
        end
        check("rsp_done_in_time", (i < 400), 1);
        tick(2);
    endtask

    // Command monitor: pops an expectation for every cmd_valid pulse
    initial begin
        cmd_exp_t e;
        bit prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge sd_clk);
            if (prev_valid) check("cmd_valid_pulse", cmd_valid, 0);
            if (cmd_valid && !prev_valid) begin
                if (exp_cmd.size() == 0) begin
                    check("unexpected_cmd", 1, 0);
                end else begin
                    e = exp_cmd.pop_front();
                    check("cmd_cycle", cyc, e.at);
                    check("cmd_index", cmd_index, e.idx);
                    check("cmd_arg", cmd_arg, e.arg);
                    check("cmd_crc_ok", cmd_crc_ok, e.ok);
                    check("cmd_frame_err", cmd_frame_err, e.ferr);
                end
            end
            prev_valid = cmd_valid;
        end
    end

    // Response monitor: collects CMD-line bits while the card drives
    initial begin
        rsp_exp_t cur;
        logic [135:0] got;
        int n, mism;
        bit prev_oe;
        prev_oe = 1'b0; n = 0; got = 136'h0;
        cur.bits = 136'h0; cur.len = 0; cur.start = 0; cur.abort_at = 0;
        forever begin
            @(negedge sd_clk);
            if (sd_cmd_oe && !prev_oe) begin
                oe_rises++;
                if (exp_rsp.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    cur = exp_rsp.pop_front();
                    mon_active = 1'b1;
                    n = 0;
                    got = 136'h0;
                    check("rsp_start_cycle", cyc, cur.start);
                end
            end
            if (sd_cmd_oe && mon_active) begin
                if (n < 136) got[135-n] = sd_cmd_from_card;
                n++;
            end
            if (!sd_cmd_oe && prev_oe && mon_active) begin
                mon_active = 1'b0;
                if (cur.abort_at > 0) begin
                    check("rsp_abort_bits", n, cur.abort_at);
                    mism = 0;
                    for (int i = 0; i < n && i < 136; i++) begin
                        if (got[135-i] !== cur.bits[135-i]) mism++;
                    end
                    check("rsp_abort_prefix", mism, 0);
                end else begin
                    check("rsp_len", n, cur.len);
                    check("rsp_bits", got, cur.bits);
                    check("rsp_oe_fall_cycle", cyc, cur.start + cur.len);
                end
                check("rsp_line_idle_high", sd_cmd_from_card, 1);
            end
            prev_oe = sd_cmd_oe;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [47:0]  tok;
        logic [127:0] r2_data;
        int saved_rises;

        // Reset values
        repeat (2) @(posedge sd_clk);
        #1;
        check("rst_from_card", sd_cmd_from_card, 1);
        check("rst_oe", sd_cmd_oe, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_index", cmd_index, 0);
        check("rst_cmd_arg", cmd_arg, 0);
        check("rst_crc_ok", cmd_crc_ok, 0);
        check("rst_frame_err", cmd_frame_err, 0);
        check("rst_rsp_ready", rsp_ready, 0);
        rst = 1'b0;
        tick(3);

        // CMD0, skipped: no response at all
        saved_rises = oe_rises;
        send_token(48'h400000000095, 6'd0, 32'h0, 1'b1, 1'b0);
        respond(1'b1, 1'b0, 1'b0, 6'd0, 128'h0, 136'h0);
        tick(10);
        check("cmd0_no_response", oe_rises, saved_rises);

        // CMD8 with early handshake, R7 echo
        send_token(48'h48000001AA87, 6'd8, 32'h000001AA, 1'b1, 1'b0);
        respond(1'b0, 1'b0, 1'b0, 6'd8, {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h000001AA},
                {2'b00, 6'd8, 32'h000001AA, crc7_model({2'b00, 6'd8, 32'h000001AA}), 1'b1, 88'h0});
        wait_rsp_done();

        // Bad CRC, bad end bit, bad transmission bit
        send_token(48'h400000000097, 6'd0, 32'h0, 1'b0, 1'b0);
        respond(1'b1, 1'b0, 1'b0, 6'd0, 128'h0, 136'h0);
        tick(2);
        send_token(48'h400000000094, 6'd0, 32'h0, 1'b1, 1'b1);
        respond(1'b1, 1'b0, 1'b0, 6'd0, 128'h0, 136'h0);
        tick(2);
        send_token(48'h000000000095, 6'd0, 32'h0, 1'b0, 1'b1);
        respond(1'b1, 1'b0, 1'b0, 6'd0, 128'h0, 136'h0);
        tick(2);

        // CMD58 -> R3 with forced CRC field
        tok = mk_token(6'd58, 32'h0);
        send_token(tok, 6'd58, 32'h0, 1'b1, 1'b0);
        respond(1'b0, 1'b0, 1'b1, 6'h3F, {96'h0, 32'h80FF8000}, {48'h3F80FF8000FF, 88'h0});
        wait_rsp_done();

        // CMD2 -> R2 long response
        r2_data = 128'h0123456789ABCDEF_FEDCBA9876543210;
        tok = mk_token(6'd2, 32'h0);
        send_token(tok, 6'd2, 32'h0, 1'b1, 1'b0);
        respond(1'b0, 1'b1, 1'b0, 6'd0, r2_data, {8'h3F, r2_data[127:1], 1'b1});
        wait_rsp_done();

        // Late handshake: start bit one cycle after the handshake
        send_token(48'h48000001AA87, 6'd8, 32'h000001AA, 1'b1, 1'b0);
        tick(20);
        respond(1'b0, 1'b0, 1'b0, 6'd8, {96'h0, 32'h12345678},
                {2'b00, 6'd8, 32'h12345678, crc7_model({2'b00, 6'd8, 32'h12345678}), 1'b1, 88'h0});
        wait_rsp_done();

        // New start bit while waiting: first request dropped, second token decoded
        saved_rises = oe_rises;
        send_token(48'h48000001AA87, 6'd8, 32'h000001AA, 1'b1, 1'b0);
        tick(5);
        check("wait_rsp_ready", rsp_ready, 1);
        send_token(48'h400000000095, 6'd0, 32'h0, 1'b1, 1'b0);
        respond(1'b1, 1'b0, 1'b0, 6'd0, 128'h0, 136'h0);
        tick(10);
        check("restart_no_response", oe_rises, saved_rises);

        // Reset in the middle of an R2 response
        abort_next = 60;
        tok = mk_token(6'd2, 32'h0);
        send_token(tok, 6'd2, 32'h0, 1'b1, 1'b0);
        respond(1'b0, 1'b1, 1'b0, 6'd0, r2_data, {8'h3F, r2_data[127:1], 1'b1});
        abort_next = 0;
        for (int i = 0; i < 400 && cyc != last_start + 60; i++) tick(1);
        check("abort_point_reached", cyc, last_start + 60);
        check("abort_oe_before_rst", sd_cmd_oe, 1);
        rst = 1'b1;
        #1;
        check("abort_oe", sd_cmd_oe, 0);
        check("abort_from_card", sd_cmd_from_card, 1);
        check("abort_rsp_ready", rsp_ready, 0);
        check("abort_cmd_index", cmd_index, 0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // CMD0 decoded normally after the reset
        send_token(48'h400000000095, 6'd0, 32'h0, 1'b1, 1'b0);
        respond(1'b1, 1'b0, 1'b0, 6'd0, 128'h0, 136'h0);
        tick(5);

        check("cmd_queue_empty", exp_cmd.size(), 0);
        check("rsp_queue_empty", exp_rsp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
